// File: rtl/ref_buf_sched.sv
// Ping-pong reference-window buffer scheduler: DMA fills one bank while the PE array drains the other.
// Optional PE-side stall counter enabled by defining REF_SCHED_PERF_EN.
module ref_buf_sched #(
  parameter int ROW_NUM = 64,
  parameter int COL_NUM = 32,
  parameter int RW      = 6,
  parameter int CW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          wr_req,
  output logic          wr_ack,
  output logic          wr_bank,
  output logic [RW-1:0] wr_addr,
  input  logic          pe_ready,
  output logic          rd_en,
  output logic          rd_bank,
  output logic [RW-1:0] rd_addr,
  output logic          strip_start,
  output logic [CW-1:0] col_idx,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_NUM - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
  localparam logic [CW:0]   LOAD_MAX = (CW+1)'(COL_NUM);

  state_t        state_r, state_s;
  logic [CW:0]   load_cnt_r;
  logic [RW-1:0] wr_row_r, rd_row_r;
  logic [CW-1:0] col_cnt_r;
  logic [1:0]    full_r, full_s;
  logic          wr_bank_r, rd_ptr_r;
  logic          done_r;
  logic          wr_ok_s, wr_ack_s, wr_last_s, rd_issue_s, rd_last_s;

  // Write handshake: PRIME only fills bank 0, so the toggle to bank 1 waits for RUN.
  always_comb begin
    wr_ok_s    = (state_r == RUN) || ((state_r == PRIME) && !wr_bank_r);
    wr_ack_s   = wr_req && wr_ok_s && !full_r[wr_bank_r] && (load_cnt_r < LOAD_MAX);
    wr_last_s  = wr_ack_s && (wr_row_r == ROW_LAST);
    rd_issue_s = (state_r == RUN) && full_r[rd_ptr_r] && pe_ready;
    rd_last_s  = rd_issue_s && (rd_row_r == ROW_LAST);
  end

  // Bank full flags: writer sets, reader clears; the two always target opposite banks.
  always_comb begin
    full_s = full_r;
    if (wr_last_s) begin
      full_s[wr_bank_r] = 1'b1;
    end else begin
      full_s = full_s;
    end
    if (rd_last_s) begin
      full_s[rd_ptr_r] = 1'b0;
    end else begin
      full_s = full_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = PRIME;
        end else begin
          state_s = IDLE;
        end
      end
      PRIME: begin
        if (full_r[0]) begin
          state_s = RUN;
        end else begin
          state_s = PRIME;
        end
      end
      RUN: begin
        if (rd_last_s && (col_cnt_r == COL_LAST)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Write/read pointers, bank flags and registered read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_r  <= '0;
      wr_row_r    <= '0;
      rd_row_r    <= '0;
      col_cnt_r   <= '0;
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_ptr_r    <= 1'b0;
      rd_en       <= 1'b0;
      rd_bank     <= 1'b0;
      rd_addr     <= '0;
      strip_start <= 1'b0;
      col_idx     <= '0;
    end else if (state_r == IDLE) begin
      load_cnt_r  <= '0;
      wr_row_r    <= '0;
      rd_row_r    <= '0;
      col_cnt_r   <= '0;
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_ptr_r    <= 1'b0;
      rd_en       <= 1'b0;
      rd_bank     <= 1'b0;
      rd_addr     <= '0;
      strip_start <= 1'b0;
      col_idx     <= '0;
    end else begin
      full_r      <= full_s;
      rd_en       <= rd_issue_s;
      strip_start <= rd_issue_s && (rd_row_r == '0);
      if (wr_last_s) begin
        wr_row_r   <= '0;
        wr_bank_r  <= ~wr_bank_r;
        load_cnt_r <= load_cnt_r + 1'b1;
      end else if (wr_ack_s) begin
        wr_row_r <= wr_row_r + 1'b1;
      end
      // Read outputs keep their last value across stalls.
      if (rd_issue_s) begin
        rd_addr <= rd_row_r;
        rd_bank <= rd_ptr_r;
        col_idx <= col_cnt_r;
        if (rd_last_s) begin
          rd_row_r <= '0;
          rd_ptr_r <= ~rd_ptr_r;
          if (col_cnt_r != COL_LAST) begin
            col_cnt_r <= col_cnt_r + 1'b1;
          end
        end else begin
          rd_row_r <= rd_row_r + 1'b1;
        end
      end
    end
  end

  // Completion pulse lands one cycle after the final read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == DONE);
    end
  end

  assign wr_ack  = wr_ack_s;
  assign wr_bank = wr_bank_r;
  assign wr_addr = wr_row_r;
  assign busy    = (state_r != IDLE);
  assign done    = done_r;

`ifdef REF_SCHED_PERF_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of RUN cycles that produce no read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == IDLE) && start) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == RUN) && !rd_issue_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ref_buf_sched.sv
// Directed bench for ref_buf_sched: nominal window, back-pressure, slow DMA, start-in-RUN and mid-run reset.
module tb_ref_buf_sched;
  localparam int ROW_NUM = 64;
  localparam int COL_NUM = 32;
  localparam int RW      = 6;
  localparam int CW      = 5;
  localparam int TOTAL   = ROW_NUM * COL_NUM;
`ifdef REF_SCHED_PERF_EN
  localparam int EXP_BP_STALL = 5;
`else
  localparam int EXP_BP_STALL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, wr_req, pe_ready;
  logic          wr_ack, wr_bank, rd_en, rd_bank, strip_start, busy, done;
  logic [RW-1:0] wr_addr, rd_addr;
  logic [CW-1:0] col_idx;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int passes = 0;
  int n_reads, n_acks, n_strips, n_dones, seq_err, viol, hold_err;
  int max_gap, first_rd, done_n, timed_out, busy_at1, aborted;
  int model_w[2];
  int model_r[2];
  bit model_full[2];

  ref_buf_sched #(.ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .pe_ready(pe_ready), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .strip_start(strip_start), .col_idx(col_idx), .busy(busy), .done(done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // Runs one window from a start pulse, scoring every cycle against a bank occupancy model.
  task automatic run_window(input int bp_k, input bit slow, input int start_col, input int rst_col);
    int n, k, last_n, bp_left;
    logic [RW-1:0] last_addr;
    bit pulsed;
    n_reads = 0; n_acks = 0; n_strips = 0; n_dones = 0; seq_err = 0; viol = 0; hold_err = 0;
    max_gap = 0; first_rd = 0; done_n = 0; timed_out = 0; busy_at1 = 0; aborted = 0;
    for (int b = 0; b < 2; b++) begin
      model_w[b] = 0; model_r[b] = 0; model_full[b] = 1'b0;
    end
    k = 0; last_n = 0; bp_left = 0; pulsed = 1'b0; last_addr = '0;
    pe_ready = 1'b1;
    wr_req = !slow;
    start = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (slow) wr_req = ((n % 4) == 0);
      if (bp_left > 0) begin
        bp_left--;
        if (bp_left == 0) pe_ready = 1'b1;
      end
      #1;
      if (n == 1) busy_at1 = int'(busy);
      if (strip_start && !rd_en) seq_err++;
      if (rd_en) begin
        if (!model_full[rd_bank]) viol++;
        if (k == 0) first_rd = n;
        else if (n - last_n - 1 > max_gap) max_gap = n - last_n - 1;
        if (rd_addr !== RW'(k % ROW_NUM) || col_idx !== CW'(k / ROW_NUM) ||
            rd_bank !== 1'((k / ROW_NUM) % 2) || strip_start !== ((k % ROW_NUM) == 0))
          seq_err++;
        model_r[rd_bank]++;
        if (model_r[rd_bank] == ROW_NUM) begin
          model_r[rd_bank] = 0;
          model_full[rd_bank] = 1'b0;
        end
        n_reads++;
        if (strip_start) n_strips++;
        last_n = n;
        last_addr = rd_addr;
        if (k == bp_k) begin
          pe_ready = 1'b0;
          bp_left = 5;
        end
        k++;
      end else if (k > 0 && k < TOTAL && rd_addr !== last_addr) begin
        hold_err++;
      end
      if (wr_ack) begin
        if (model_full[wr_bank]) viol++;
        if (wr_addr !== RW'(model_w[wr_bank])) seq_err++;
        model_w[wr_bank]++;
        if (model_w[wr_bank] == ROW_NUM) begin
          model_w[wr_bank] = 0;
          model_full[wr_bank] = 1'b1;
        end
        n_acks++;
      end
      if (done) begin
        n_dones++;
        if (done_n == 0) done_n = n;
      end
      if (start_col >= 0 && rd_en && col_idx == CW'(start_col) && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (rst_col >= 0 && rd_en && col_idx == CW'(rst_col)) begin
        rst_n = 1'b0;
        aborted = 1;
        break;
      end
      if (done_n > 0 && n >= done_n + 3) break;
      if (n >= 20000) begin
        timed_out = 1;
        break;
      end
    end
    wr_req = 1'b0;
    pe_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_req = 1'b0; pe_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 64'({wr_ack, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, strip_start,
                                col_idx, busy, done, stall_cnt}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal window with continuous supply; wr_req stays high past the last load.
    run_window(-1, 1'b0, -1, -1);
    check("nom_timeout",    64'(timed_out), 64'd0);
    check("nom_busy_e1",    64'(busy_at1),  64'd1);
    check("nom_reads",      64'(n_reads),   64'(TOTAL));
    check("nom_acks",       64'(n_acks),    64'(TOTAL));
    check("nom_strips",     64'(n_strips),  64'(COL_NUM));
    check("nom_dones",      64'(n_dones),   64'd1);
    check("nom_sequence",   64'(seq_err),   64'd0);
    check("nom_bank_safe",  64'(viol),      64'd0);
    check("nom_first_rd",   64'(first_rd),  64'd67);
    check("nom_done_cycle", 64'(done_n),    64'd2115);
    check("nom_max_gap",    64'(max_gap),   64'd0);
    check("nom_stall_cnt",  64'(stall_cnt), 64'd0);
    check("nom_idle_busy",  64'(busy),      64'd0);

    // PE back-pressure after row 20 of strip 3.
    run_window(3 * ROW_NUM + 20, 1'b0, -1, -1);
    check("bp_reads",      64'(n_reads),   64'(TOTAL));
    check("bp_gap",        64'(max_gap),   64'd5);
    check("bp_sequence",   64'(seq_err),   64'd0);
    check("bp_addr_hold",  64'(hold_err),  64'd0);
    check("bp_dones",      64'(n_dones),   64'd1);
    check("bp_done_cycle", 64'(done_n),    64'd2120);
    check("bp_stall_cnt",  64'(stall_cnt), 64'(EXP_BP_STALL));

    // Slow DMA: one request every fourth cycle.
    run_window(-1, 1'b1, -1, -1);
    check("slow_timeout",   64'(timed_out), 64'd0);
    check("slow_reads",     64'(n_reads),   64'(TOTAL));
    check("slow_acks",      64'(n_acks),    64'(TOTAL));
    check("slow_bank_safe", 64'(viol),      64'd0);
    check("slow_sequence",  64'(seq_err),   64'd0);
    check("slow_addr_hold", 64'(hold_err),  64'd0);
    check("slow_dones",     64'(n_dones),   64'd1);

    // start pulsed while reading strip 10 is ignored.
    run_window(-1, 1'b0, 10, -1);
    check("srun_reads",      64'(n_reads),  64'(TOTAL));
    check("srun_dones",      64'(n_dones),  64'd1);
    check("srun_done_cycle", 64'(done_n),   64'd2115);
    check("srun_sequence",   64'(seq_err),  64'd0);

    // Reset during strip 17, then a fresh window.
    run_window(-1, 1'b0, -1, 17);
    check("rst_reached", 64'(aborted), 64'd1);
    @(negedge clk);
    #1;
    check("rst_outputs", 64'({wr_ack, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, strip_start,
                              col_idx, busy, done, stall_cnt}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_window(-1, 1'b0, -1, -1);
    check("rerun_reads",      64'(n_reads),  64'(TOTAL));
    check("rerun_acks",       64'(n_acks),   64'(TOTAL));
    check("rerun_first_rd",   64'(first_rd), 64'd67);
    check("rerun_done_cycle", 64'(done_n),   64'd2115);
    check("rerun_sequence",   64'(seq_err),  64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ref_buf_sched.md
# ref_buf_sched

Scheduler for the two-bank ping-pong reference-window buffer that feeds the ME PE array. It arbitrates the buffer between the DMA loader (writes) and the PE array (reads). It sequences one full search window as COL_NUM column strips of ROW_NUM rows each. It tracks per-bank full/empty state, generates bank-select and row addresses for both sides, stalls on PE back-pressure, and reports strip boundaries and completion to the PE array controller.

## Interface
Parameters:
- ROW_NUM, 64: rows per column strip (rows per bank).
- COL_NUM, 32: column strips per search window.
- RW, 6: row address width; must satisfy 2^RW >= ROW_NUM.
- CW, 5: strip index width; must satisfy 2^CW >= COL_NUM.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; one clock, async active-low reset, all state cleared.
- start  in  1  pulse; begins a window; ignored unless in IDLE.
- wr_req  in  1  DMA holds a reference row word.
- wr_ack  out  1  combinational; row word written this cycle.
- wr_bank  out  1  bank targeted by DMA.
- wr_addr  out  RW  row index in wr_bank.
- pe_ready  in  1  PE array accepts a row this cycle.
- rd_en  out  1  registered; row read strobe to buffer.
- rd_bank  out  1  registered; bank being read.
- rd_addr  out  RW  registered; row index being read.
- strip_start  out  1  registered; high with rd_en on row 0 of each strip.
- col_idx  out  CW  registered; strip currently being read.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the window is finished.
- stall_cnt  out  16  PE-side stall cycles (see Configuration).

## Operation
- States: IDLE, PRIME, RUN, DONE.
- **IDLE:**
  - Clears load_cnt, wr_row, rd_row, col_idx, full[1:0], wr_bank=0, rd_bank=0.
  - start -> PRIME.
- **PRIME:**
  - Accepts writes into bank 0 only; no reads.
  - When bank 0 is full -> RUN.
- **RUN:** reads and writes are concurrent and always target opposite banks.
  - wr_ack = wr_req & (PRIME|RUN) & !full[wr_bank] & (load_cnt < COL_NUM).
  - Each ack increments wr_row. On the ack with wr_row==ROW_NUM-1:
    - full[wr_bank] <= 1, wr_row <= 0, wr_bank toggles, load_cnt++.
  - Read issue condition: full[rd_bank] & pe_ready. On issue:
    - rd_en <= 1, rd_addr <= rd_row, rd_row++.
  - Otherwise rd_en <= 0 (stall).
  - On the issue with rd_row==ROW_NUM-1:
    - full[rd_bank] <= 0, rd_bank toggles, rd_row <= 0.
    - If col_idx==COL_NUM-1 -> DONE; else col_idx++.
- **DONE:** done=1 for one cycle -> IDLE.
- A bank is never written while full and never read while empty. Set and clear of the same bank in one cycle is therefore impossible.
- wr_req after load_cnt==COL_NUM: wr_ack stays low.
- start while busy: ignored.
- Reset mid-operation: immediate return to IDLE. The next start reloads from strip 0.

## Timing
- Reset values: wr_ack=0, wr_bank=0, wr_addr=0, rd_en=0, rd_bank=0, rd_addr=0, strip_start=0, col_idx=0, busy=0, done=0, stall_cnt=0.
- start sampled at edge E: busy=1 from E+1.
- Last write of a bank acked in cycle N: full flag visible from N+1. First rd_en for that bank can be high at N+2.
- With continuous wr_req and pe_ready:
  - PRIME lasts ROW_NUM+1 cycles.
  - Reads are then back-to-back across strips, with no bubble at bank switches.
  - done follows the final rd_en by 1 cycle.
- pe_ready low in cycle N: rd_en=0 at N+1; rd_addr holds its value.
- wr_addr/wr_bank change only on acked writes.

## Configuration
- REF_SCHED_PERF_EN defined:
  - stall_cnt increments (saturating at 16'hFFFF) every RUN cycle in which rd_en is registered 0.
  - Cleared on start.
- REF_SCHED_PERF_EN undefined: stall_cnt tied to 0; no counter logic.

## Test plan
- Nominal: start, wr_req=1, pe_ready=1 -> 2048 rd_en pulses; strip_start on every 64th; col_idx steps 0..31; rd_bank alternates; one done pulse; 2048 wr_acks.
- PE back-pressure: pe_ready low for 5 cycles mid-strip 3 at row 20 -> rd_en gap of 5; rd_addr resumes at 21; total reads still 2048; stall_cnt=5 with REF_SCHED_PERF_EN.
- Slow DMA: wr_req every 4th cycle -> reads of strip k+1 never begin before bank full; no read of an empty bank; no write to a full bank (assertion).
- Over-supply: wr_req held high after 32 strips loaded -> wr_ack=0 for the rest of RUN.
- start pulsed in RUN at col_idx=10 -> ignored; sequence and done unchanged.
- rst_n low at col_idx=17 -> all outputs at reset values next cycle; new start -> nominal sequence from strip 0.
